// File: rtl/seq_chk.sv
// seq_chk: locks onto a pattern sequencer's period and flags every sample that deviates from the table.
// Define SEQ_CHK_ERRCNT_EN to build the saturating ERR_CNT counter; otherwise ERR_CNT is tied to 0.
module seq_chk #(
  parameter int BW_SEQ     = 6,
  parameter int SEQ_CNT    = 5,
  parameter int BW_SEQ_CNT = 3,
  parameter int BW_TIMEOUT = 3,
  parameter int BW_ERRCNT  = 8
) (
  input  logic                                         CLK,
  input  logic                                         RSTX,
  input  logic                                         CLR,
  input  logic [(SEQ_CNT+1)*(BW_SEQ+BW_TIMEOUT)-1:0]   PTN,
  input  logic [BW_SEQ-1:0]                            SEQ_IN,
  output logic                                         LOCK,
  output logic                                         ERR,
  output logic [BW_SEQ_CNT-1:0]                        STEP,
  output logic [BW_ERRCNT-1:0]                         ERR_CNT
);
  localparam int EW = BW_SEQ + BW_TIMEOUT;
  localparam int NS = 2 ** BW_SEQ_CNT;
  localparam logic [BW_SEQ_CNT-1:0] LAST  = BW_SEQ_CNT'(SEQ_CNT);
  localparam logic [BW_SEQ_CNT-1:0] STEP1 = (SEQ_CNT == 0) ? '0 : BW_SEQ_CNT'(1);
  typedef enum logic {HUNT, TRACK} state_t;
  state_t                  state_q, state_d;
  logic [BW_SEQ_CNT-1:0]   step_q, step_d;
  logic [BW_TIMEOUT-1:0]   cnt_q, cnt_d;
  logic [BW_SEQ-1:0]       prev_q;
  logic                    lock_q, lock_d, err_q, err_d, hit, boundary;
  logic [BW_SEQ-1:0]       pat [NS];
  logic [BW_TIMEOUT-1:0]   to  [NS];
  // Table padded to a power of two so STEP can index it directly; unused slots read 0.
  for (genvar k = 0; k < NS; k++) begin : g_tab
    if (k <= SEQ_CNT) begin : g_ent
      assign pat[k] = PTN[(SEQ_CNT-k)*EW+BW_TIMEOUT +: BW_SEQ];
      assign to[k]  = PTN[(SEQ_CNT-k)*EW +: BW_TIMEOUT];
    end else begin : g_pad
      assign pat[k] = '0;
      assign to[k]  = '0;
    end
  end
  assign hit      = SEQ_IN == pat[step_q];
  assign boundary = SEQ_IN == pat[0] && prev_q == pat[SEQ_CNT];
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    lock_d  = lock_q;
    err_d   = 1'b0;
    if (CLR) begin
      state_d = HUNT;
      step_d  = '0;
      cnt_d   = '0;
      lock_d  = 1'b0;
    end else if (state_q == HUNT) begin
      if (boundary) begin
        state_d = TRACK;
        step_d  = to[0] == '0 ? STEP1 : '0;
        cnt_d   = to[0] == '0 ? '0 : BW_TIMEOUT'(1);
      end
    end else if (!hit) begin
      state_d = HUNT;
      step_d  = '0;
      cnt_d   = '0;
      lock_d  = 1'b0;
      err_d   = 1'b1;
    end else begin
      // Step 0 with cnt 0 is only reachable in TRACK through a wrap, i.e. after a full clean period.
      lock_d = lock_q | (step_q == '0 && cnt_q == '0);
      cnt_d  = cnt_q == to[step_q] ? '0 : cnt_q + 1'b1;
      step_d = cnt_q != to[step_q] ? step_q : step_q == LAST ? '0 : step_q + 1'b1;
    end
  end
  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      state_q <= HUNT;
      step_q  <= '0;
      cnt_q   <= '0;
      prev_q  <= '0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      prev_q  <= SEQ_IN;
      lock_q  <= lock_d;
      err_q   <= err_d;
    end
  end
`ifdef SEQ_CHK_ERRCNT_EN
  logic [BW_ERRCNT-1:0] err_cnt_q, err_cnt_d;
  assign err_cnt_d = CLR ? '0 : (err_d && !(&err_cnt_q)) ? err_cnt_q + 1'b1 : err_cnt_q;
  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) err_cnt_q <= '0;
    else err_cnt_q <= err_cnt_d;
  end
  assign ERR_CNT = err_cnt_q;
`else
  assign ERR_CNT = '0;
`endif
  assign LOCK = lock_q;
  assign ERR  = err_q;
  assign STEP = step_q;
endmodule

// File: tb/tb_seq_chk.sv
// tb_seq_chk: randomized scoreboard bench; a position-in-period model predicts LOCK/ERR/STEP/ERR_CNT each cycle.
module tb_seq_chk;
  localparam int NE = 6, EW = 9, BW_ERRCNT = 2, SAT = 3;
  logic                 CLK = 1'b0, RSTX = 1'b0, CLR = 1'b0;
  logic [NE*EW-1:0]     PTN;
  logic [5:0]           SEQ_IN = '0;
  logic                 LOCK, ERR;
  logic [2:0]           STEP;
  logic [BW_ERRCNT-1:0] ERR_CNT;
  seq_chk #(.BW_ERRCNT(BW_ERRCNT)) dut (
    .CLK(CLK), .RSTX(RSTX), .CLR(CLR), .PTN(PTN), .SEQ_IN(SEQ_IN),
    .LOCK(LOCK), .ERR(ERR), .STEP(STEP), .ERR_CNT(ERR_CNT)
  );
  always #5 CLK = ~CLK;
  typedef struct {bit lock; bit err; int step; int ecnt;} exp_t;
  exp_t       q[$];
  int         checks = 0, errors = 0;
  logic [5:0] tpat[NE];
  logic [2:0] tto[NE];
  logic [5:0] xpat[$];
  int         xstep[$];
  int         P, g_pos;
  bit         m_hunt, m_lock, m_err;
  int         m_pos, m_run, m_errs;
  logic [5:0] m_prev;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  function automatic int ecnt_exp();
`ifdef SEQ_CHK_ERRCNT_EN
    return m_errs;
`else
    return 0;
`endif
  endfunction
  task automatic set_table(input int sel);
    for (int k = 0; k < NE; k++) begin
      tpat[k] = sel == 0 ? 6'(1 << k) : 6'(k == 0 ? 'h3F : k == 1 ? 'h15 : k == 2 ? 'h2A : k == 3 ? 'h07 : k == 4 ? 'h38 : 'h11);
      tto[k]  = sel == 0 ? 3'(k) : 3'(k == 0 ? 7 : k == 1 ? 0 : k == 2 ? 7 : k == 3 ? 1 : k == 4 ? 0 : 3);
      PTN[(NE-1-k)*EW +: EW] = {tpat[k], tto[k]};
    end
    xpat.delete();
    xstep.delete();
    for (int k = 0; k < NE; k++)
      for (int j = 0; j <= int'(tto[k]); j++) begin
        xpat.push_back(tpat[k]);
        xstep.push_back(k);
      end
    P = xpat.size();
  endtask
  task automatic mdl_reset();
    m_hunt = 1; m_lock = 0; m_err = 0; m_pos = 0; m_run = 0; m_errs = 0; m_prev = '0;
  endtask
  // Called at a falling edge: drive one sample, predict the response of the next rising edge.
  task automatic cyc(input logic [5:0] s, input bit clr);
    SEQ_IN = s;
    CLR = clr;
    m_err = 0;
    if (clr) begin
      m_hunt = 1; m_pos = 0; m_lock = 0; m_errs = 0;
    end else if (m_hunt) begin
      if (s == tpat[0] && m_prev == tpat[NE-1]) begin
        m_hunt = 0; m_pos = 1 % P; m_run = 1;
      end
    end else if (s == xpat[m_pos]) begin
      m_pos = (m_pos + 1) % P;
      if (m_run <= P) m_run++;
      if (m_run > P) m_lock = 1;
    end else begin
      m_err = 1; m_hunt = 1; m_pos = 0; m_lock = 0;
      if (m_errs < SAT) m_errs++;
    end
    m_prev = s;
    q.push_back('{m_lock, m_err, m_hunt ? 0 : xstep[m_pos], ecnt_exp()});
    @(negedge CLK);
  endtask
  task automatic clean(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(xpat[g_pos], 0);
      g_pos = (g_pos + 1) % P;
    end
  endtask
  task automatic corrupt(input logic [5:0] s, input bit clr);
    cyc(s, clr);
    g_pos = (g_pos + 1) % P;
  endtask
  task automatic do_reset(input int n);
    RSTX = 1'b0;
    SEQ_IN = '0;
    CLR = 1'b0;
    #1;
    chk("rst_lock", LOCK, 0);
    chk("rst_err", ERR, 0);
    chk("rst_step", STEP, 0);
    chk("rst_errcnt", ERR_CNT, 0);
    mdl_reset();
    repeat (n) @(negedge CLK);
    RSTX = 1'b1;
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("lock", LOCK, e.lock);
        chk("err", ERR, e.err);
        chk("step", STEP, e.step);
        chk("errcnt", ERR_CNT, e.ecnt);
      end
    end
  end
  initial begin
    int r;
    set_table(0);
    g_pos = 0;
    repeat (2) @(negedge CLK);
    do_reset(0);
    clean(70);
    while (xstep[g_pos] != 3) clean(1);
    clean(1);
    corrupt(6'h00, 0);
    clean(50);
    while (xstep[g_pos] != 5) clean(1);
    g_pos = (g_pos + 1) % P;
    clean(50);
    for (int i = 0; i < 5; i++) begin
      corrupt(6'h00, 0);
      clean(30);
    end
    corrupt(6'h00, 1);
    clean(50);
    repeat (7) clean(1);
    do_reset(2);
    clean(60);
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) corrupt(6'h00, 0);
      else if (r < 4) begin
        g_pos = (g_pos + 1) % P;
        clean(1);
      end else if (r < 5) corrupt(6'($urandom), 0);
      else if (r == 5) corrupt(xpat[g_pos], 1);
      else clean(1);
    end
    set_table(1);
    g_pos = $urandom_range(0, P - 1);
    corrupt(xpat[g_pos], 1);
    clean(150);
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) corrupt(6'($urandom), 0);
      else if (r == 2) corrupt(xpat[g_pos], 1);
      else clean(1);
    end
    @(posedge CLK);
    #2;
    if (q.size() != 0) chk("drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
